seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Iterative shift-add unsigned multiplier; the inverse-operation companion to the sequential divider.
- Uses the same start/done handshake and a fixed N+1-cycle result latency, so ALU sequencing logic drives both units identically.
- Produces the full 2N-bit product: low half on result, high half on result_hi, plus an overflow flag.
- Sits beside the divider in the per-thread ALU path.

Parameters:
N, 8, operand width in bits; result and result_hi are each N bits wide.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  request level; a rising edge (high now, low on previous sampled edge) launches an operation
multiplicand  input  N  operand A, captured on the launch edge
multiplier  input  N  operand B, captured on the launch edge
result  output  N  product bits [N-1:0]
result_hi  output  N  product bits [2N-1:N]
overflow  output  1  1 when result_hi != 0
busy  output  1  1 while in RUN
done  output  1  1 while in DONE; result/result_hi/overflow valid

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; count=0; start_q=0.
  - result, result_hi, overflow, busy, done all 0.
  - Accumulator and operand registers cleared.
- start_q: registered copy of start, updated every edge. Launch condition = state IDLE && start && !start_q.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On launch edge T: latch operands; acc (N+1 bits, carry included)=0; count=0; go to RUN.
  - start held high from a previous operation (start_q=1) does not launch.
- RUN (busy=1, done=0):
  - Each edge: if LSB of shifted-multiplier register is 1, acc = acc + multiplicand.
  - Then right-shift {acc, mq} by one bit, carry entering at the top.
  - count increments.
  - On the edge where count==N-1 (edge T+N): load result, result_hi and overflow from the final product; go to DONE.
  - start is ignored in RUN; deasserting it does not abort the operation.
- Latency:
  - done is registered and first sampled high at edge T+N+1.
  - result, result_hi and overflow are valid and correct at that same edge.
- DONE (done=1, busy=0):
  - Stays in DONE while start=1.
  - First edge sampling start=0 goes to IDLE; done deasserts after that edge.
  - If start was already low at completion, DONE lasts exactly one cycle.
- Output hold: result, result_hi and overflow hold their values in IDLE until the next completion. They are not cleared on a new launch; only reset clears them.
- Back-to-back: a new operation needs start low for at least one sampled edge, then high again.
  - Earliest relaunch is the edge after DONE exits to IDLE.
  - A rising start seen in DONE is not a launch.
- Arithmetic:
  - Unsigned; product = multiplicand * multiplier, exact, 2N bits.
  - No saturation; low half is the truncated result; overflow = |result_hi.
- Zero operands: no special case; product 0, overflow 0, same latency.
- Reset mid-operation: immediate abort to IDLE with all outputs 0. No residual state; the next launch behaves as after power-up.
- Simultaneous events: operand changes during RUN have no effect, since operands were latched at launch.

Test Plan:
- N=8, start 0→1 with multiplicand=13, multiplier=11 at edge T, start held high:
  - busy=1 at edges T+1..T+N.
  - done=1 at T+9 with result=0x8F, result_hi=0x00, overflow=0.
  - done stays 1 until start drops, then 0 one edge later.
- 255*255:
  - result=0x01, result_hi=0xFE, overflow=1 at T+9.
  - Then 1*1 after start low/high: result=0x01, result_hi=0x00, overflow=0.
- 0*200 and 200*0:
  - result=0, result_hi=0, overflow=0, done exactly at T+9.
  - start pulsed for one cycle only: done high for exactly one cycle.
- Start held high across completion and for 5 more cycles:
  - No relaunch; busy stays 0; outputs unchanged.
  - Drop start one cycle, raise again: new launch, done at new T+9.
- Operands changed every cycle and start dropped during RUN:
  - Product of the operands latched at T (e.g. 100*3: result=0x2C, result_hi=0x01, overflow=1) still appears at T+9.
- reset=0 asserted asynchronously mid-RUN at T+4:
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, a new launch 7*9 gives result=0x3F at T'+9.

Source files
------------

// File: rtl/seq_multiplier.sv
// Iterative shift-add unsigned multiplier, N+1 cycle latency, start/done handshake.
// Ports: clk, reset (async active-low), start, multiplicand, multiplier,
//        result (product low half), result_hi (high half), overflow, busy, done.
module seq_multiplier #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] multiplicand,
   input  logic [N-1:0] multiplier,
   output logic [N-1:0] result,
   output logic [N-1:0] result_hi,
   output logic         overflow,
   output logic         busy,
   output logic         done
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            start_q;
   logic [CW-1:0]   count_q, count_d;
   logic [N:0]      acc_q, acc_d;
   logic [N-1:0]    mq_q, mq_d;
   logic [N-1:0]    mcand_q, mcand_d;
   logic [N-1:0]    res_lo_q, res_lo_d;
   logic [N-1:0]    res_hi_q, res_hi_d;
   logic            ovf_q, ovf_d;

   logic [N:0]      sum;
   logic [2*N:0]    shifted;
   logic [N:0]      acc_n;
   logic [N-1:0]    mq_n;

   // One shift-add step: conditionally add, then shift {acc, mq} right
   // with the carry entering at the top.
   always_comb begin
      sum     = acc_q + {1'b0, (mq_q[0] ? mcand_q : {N{1'b0}})};
      shifted = {sum, mq_q} >> 1;
      acc_n   = shifted[2*N:N];
      mq_n    = shifted[N-1:0];
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      acc_d    = acc_q;
      mq_d     = mq_q;
      mcand_d  = mcand_q;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      ovf_d    = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (start && !start_q) begin
               mcand_d = multiplicand;
               mq_d    = multiplier;
               acc_d   = '0;
               count_d = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d   = acc_n;
            mq_d    = mq_n;
            count_d = count_q + CW'(1);
            if (count_q == LAST) begin
               res_lo_d = mq_n;
               res_hi_d = acc_n[N-1:0];
               ovf_d    = |acc_n[N-1:0];
               state_d  = DONE;
            end
         end
         DONE: begin
            if (!start) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         start_q  <= 1'b0;
         count_q  <= '0;
         acc_q    <= '0;
         mq_q     <= '0;
         mcand_q  <= '0;
         res_lo_q <= '0;
         res_hi_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         start_q  <= start;
         count_q  <= count_d;
         acc_q    <= acc_d;
         mq_q     <= mq_d;
         mcand_q  <= mcand_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
         ovf_q    <= ovf_d;
      end
   end

   assign result    = res_lo_q;
   assign result_hi = res_hi_q;
   assign overflow  = ovf_q;
   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: table vectors, random operands
// against an arithmetic product model, and hand-written handshake sequences.
module tb_seq_multiplier;

   localparam int N = 8;

   logic         clk;
   logic         reset;
   logic         start;
   logic [N-1:0] multiplicand;
   logic [N-1:0] multiplier;
   logic [N-1:0] result;
   logic [N-1:0] result_hi;
   logic         overflow;
   logic         busy;
   logic         done;

   int n_vec = 0;
   int n_err = 0;

   seq_multiplier #(.N(N)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .result       (result),
      .result_hi    (result_hi),
      .overflow     (overflow),
      .busy         (busy),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      bit           hold;
      logic [N-1:0] lo;
      logic [N-1:0] hi;
      logic         ov;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launches a*b on the next edge; expects start low and unit idle.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit hold, input logic [N-1:0] elo,
                         input logic [N-1:0] ehi, input logic eov);
      multiplicand = a;
      multiplier   = b;
      start        = 1'b1;
      tick();
      if (!hold) start = 1'b0;
      for (int k = 1; k <= N; k++) begin
         chk("busy_run", busy, 1);
         chk("done_run", done, 0);
         tick();
      end
      chk("done_lat", done, 1);
      chk("busy_done", busy, 0);
      chk("result", result, elo);
      chk("result_hi", result_hi, ehi);
      chk("overflow", overflow, eov);
      if (hold) begin
         for (int k = 0; k < 5; k++) begin
            tick();
            chk("done_held", done, 1);
            chk("busy_held", busy, 0);
            chk("result_held", result, elo);
         end
         start = 1'b0;
      end
      tick();
      chk("done_exit", done, 0);
      chk("busy_idle", busy, 0);
      chk("result_idle", result, elo);
      chk("hi_idle", result_hi, ehi);
   endtask

   initial begin
      logic [2*N-1:0] p;
      logic [N-1:0]   ra, rb;
      bit             rh;

      tbl[0] = '{8'd13,  8'd11,  1'b1, 8'h8F, 8'h00, 1'b0};
      tbl[1] = '{8'd255, 8'd255, 1'b0, 8'h01, 8'hFE, 1'b1};
      tbl[2] = '{8'd1,   8'd1,   1'b0, 8'h01, 8'h00, 1'b0};
      tbl[3] = '{8'd0,   8'd200, 1'b0, 8'h00, 8'h00, 1'b0};
      tbl[4] = '{8'd200, 8'd0,   1'b0, 8'h00, 8'h00, 1'b0};
      tbl[5] = '{8'd100, 8'd3,   1'b1, 8'h2C, 8'h01, 1'b1};
      tbl[6] = '{8'd7,   8'd9,   1'b0, 8'h3F, 8'h00, 1'b0};

      reset        = 1'b0;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      tick();
      tick();
      chk("rst_result", result, 0);
      chk("rst_hi", result_hi, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      reset = 1'b1;
      tick();

      for (int i = 0; i < 7; i++) begin
         run_op(tbl[i].a, tbl[i].b, tbl[i].hold,
                tbl[i].lo, tbl[i].hi, tbl[i].ov);
      end

      // start high before the unit is idle-armed must not launch
      start = 1'b1;
      multiplicand = 8'd3;
      multiplier   = 8'd5;
      run_op(8'd2, 8'd2, 1'b1, 8'h04, 8'h00, 1'b0);

      // operands wiggle and start drops during RUN
      multiplicand = 8'd100;
      multiplier   = 8'd3;
      start        = 1'b1;
      tick();
      for (int k = 1; k <= N; k++) begin
         multiplicand = N'($urandom);
         multiplier   = N'($urandom);
         if (k == 2) start = 1'b0;
         tick();
      end
      chk("wig_done", done, 1);
      chk("wig_result", result, 8'h2C);
      chk("wig_hi", result_hi, 8'h01);
      chk("wig_ovf", overflow, 1);
      tick();
      chk("wig_exit", done, 0);

      // random operands against the arithmetic model
      for (int i = 0; i < 24; i++) begin
         ra = N'($urandom);
         rb = N'($urandom);
         rh = 1'($urandom);
         p  = (2*N)'(ra) * (2*N)'(rb);
         run_op(ra, rb, rh, p[N-1:0], p[2*N-1:N], p[2*N-1:N] != 0);
      end

      // async reset mid-RUN
      run_op(8'd200, 8'd200, 1'b0, 8'h40, 8'h9C, 1'b1);
      multiplicand = 8'd50;
      multiplier   = 8'd50;
      start        = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      #2;
      reset = 1'b0;
      #1;
      chk("ar_result", result, 0);
      chk("ar_hi", result_hi, 0);
      chk("ar_ovf", overflow, 0);
      chk("ar_busy", busy, 0);
      chk("ar_done", done, 0);
      tick();
      reset = 1'b1;
      tick();
      chk("post_rst_busy", busy, 0);
      run_op(8'd7, 8'd9, 1'b0, 8'h3F, 8'h00, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
